// File: rtl/sync_fifo_defs.sv
// Shared definitions for sync_fifo_thresh and the board tops that use it:
// clog2 helper for port widths and bit positions of a packed status word.
package sync_fifo_defs;

   // Bit positions used by board tops when packing FIFO status onto LEDs
   localparam int EMPTY = 0;
   localparam int FULL  = 1;
   localparam int AE    = 2;
   localparam int AF    = 3;
   localparam int WERR  = 4;
   localparam int RERR  = 5;

   localparam int NFLAGS = 6;

   typedef logic [NFLAGS-1:0] fifo_flags_t;

   // Ceiling log2; sf_clog2(1) = 0
   function automatic int sf_clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r = r + 1;
         x = x >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_regfile.sv
// Storage array for sync_fifo_thresh: DEPTH x DATA_WIDTH registers,
// one synchronous write port (we/waddr/wdata), one async read port (raddr/rdata).
module fifo_regfile #(
   parameter int DATA_WIDTH = 4,
   parameter int DEPTH      = 8,
   parameter int AW         = 3
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   // Contents are deliberately not reset; occupancy tracking makes
   // stale words unobservable.
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_thresh.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/empty
// thresholds, registered flags and non-power-of-two depth support.
// Ports: clk, rst (async active-high), en strobe qualifying we/re, din/dout,
// count, empty, full, almost_empty, almost_full, wr_err/rd_err pulses.
// Macro SYNC_FIFO_FWFT_EN selects first-word-fall-through dout.
module sync_fifo_thresh
   import sync_fifo_defs::*;
#(
   parameter  int DATA_WIDTH = 4,
   parameter  int FIFO_DEPTH = 8,
   parameter  int AF_LEVEL   = FIFO_DEPTH - 1,
   parameter  int AE_LEVEL   = 1,
   localparam int CW         = sf_clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  we,
   input  logic                  re,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic [CW-1:0]         count,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_empty,
   output logic                  almost_full,
   output logic                  wr_err,
   output logic                  rd_err
);

   localparam int AW = sf_clog2(FIFO_DEPTH);

   localparam logic [AW-1:0] PTR_LAST = AW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] AE_LVL   = CW'(AE_LEVEL);
   localparam logic [CW-1:0] AF_LVL   = CW'(AF_LEVEL);

   if (FIFO_DEPTH < 2 ||
       AF_LEVEL < 0 || AF_LEVEL > FIFO_DEPTH ||
       AE_LEVEL < 0 || AE_LEVEL > FIFO_DEPTH) begin : g_cfg_err
      $error("sync_fifo_thresh: depth or threshold out of range");
   end

   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count_q;
   logic [CW-1:0]         count_nxt;
   logic                  empty_q;
   logic                  full_q;
   logic                  ae_q;
   logic                  af_q;
   logic                  wr_err_q;
   logic                  rd_err_q;
   logic                  rd_ok;
   logic                  wr_ok;
   logic [DATA_WIDTH-1:0] rdata;

   // A read frees a slot in the same edge, so a full FIFO still accepts
   // a write paired with a read.
   assign rd_ok = en & re & ~empty_q;
   assign wr_ok = en & we & (~full_q | rd_ok);

   always_comb begin
      count_nxt = count_q;
      unique case ({wr_ok, rd_ok})
         2'b10:   count_nxt = count_q + 1'b1;
         2'b01:   count_nxt = count_q - 1'b1;
         default: count_nxt = count_q;
      endcase
   end

   // Explicit wrap: depth need not be a power of two
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         ae_q     <= 1'b1;
         af_q     <= (AF_LEVEL == 0);
         wr_err_q <= 1'b0;
         rd_err_q <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (rd_ok) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         count_q  <= count_nxt;
         // Flags come from the next count so they line up with count
         empty_q  <= (count_nxt == '0);
         full_q   <= (count_nxt == CNT_MAX);
         ae_q     <= (count_nxt <= AE_LVL);
         af_q     <= (count_nxt >= AF_LVL);
         wr_err_q <= en & we & ~wr_ok;
         rd_err_q <= en & re & ~rd_ok;
      end
   end

   fifo_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH),
      .AW         (AW)
   ) u_regfile (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (wr_ptr),
      .wdata (din),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

`ifdef SYNC_FIFO_FWFT_EN
   // Head word is presented combinationally; forced to 0 while empty
   assign dout = empty_q ? '0 : rdata;
`else
   logic [DATA_WIDTH-1:0] dout_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_q <= '0;
      end else if (rd_ok) begin
         dout_q <= rdata;
      end
   end

   assign dout = dout_q;
`endif

   assign count        = count_q;
   assign empty        = empty_q;
   assign full         = full_q;
   assign almost_empty = ae_q;
   assign almost_full  = af_q;
   assign wr_err       = wr_err_q;
   assign rd_err       = rd_err_q;

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Directed bench for sync_fifo_thresh: default 8-deep instance plus a
// 6-deep instance for pointer wrap. Expectations adapt to SYNC_FIFO_FWFT_EN.
module tb_sync_fifo_thresh;

`ifdef SYNC_FIFO_FWFT_EN
   localparam bit FWFT = 1'b1;
`else
   localparam bit FWFT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       en8 = 1'b0, we8 = 1'b0, re8 = 1'b0;
   logic [3:0] din8 = '0;
   logic [3:0] dout8;
   logic [3:0] count8;
   logic       empty8, full8, ae8, af8, werr8, rerr8;

   logic       en6 = 1'b0, we6 = 1'b0, re6 = 1'b0;
   logic [3:0] din6 = '0;
   logic [3:0] dout6;
   logic [2:0] count6;
   logic       empty6, full6, ae6, af6, werr6, rerr6;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   sync_fifo_thresh u_d8 (
      .clk          (clk),
      .rst          (rst),
      .en           (en8),
      .we           (we8),
      .re           (re8),
      .din          (din8),
      .dout         (dout8),
      .count        (count8),
      .empty        (empty8),
      .full         (full8),
      .almost_empty (ae8),
      .almost_full  (af8),
      .wr_err       (werr8),
      .rd_err       (rerr8)
   );

   sync_fifo_thresh #(.FIFO_DEPTH(6)) u_d6 (
      .clk          (clk),
      .rst          (rst),
      .en           (en6),
      .we           (we6),
      .re           (re6),
      .din          (din6),
      .dout         (dout6),
      .count        (count6),
      .empty        (empty6),
      .full         (full6),
      .almost_empty (ae6),
      .almost_full  (af6),
      .wr_err       (werr6),
      .rd_err       (rerr6)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_chk = n_chk + 1;
      if (obs == exp) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock of stimulus on the selected instance; outputs settle by #1
   task automatic op(input int sel, input logic w, input logic r,
                     input logic [3:0] d, input logic e = 1'b1);
      @(negedge clk);
      if (sel == 8) begin
         en8 = e; we8 = w; re8 = r; din8 = d;
      end else begin
         en6 = e; we6 = w; re6 = r; din6 = d;
      end
      @(posedge clk);
      #1;
      en8 = 1'b0; we8 = 1'b0; re8 = 1'b0;
      en6 = 1'b0; we6 = 1'b0; re6 = 1'b0;
   endtask

   function automatic int dsel(input int sel);
      return (sel == 8) ? int'(dout8) : int'(dout6);
   endfunction

   // FWFT shows the head before the read; registered mode shows it after
   task automatic rd(input int sel, input int x, input string tag);
      if (FWFT) begin
         check(tag, dsel(sel), x);
         op(sel, 1'b0, 1'b1, 4'h0);
      end else begin
         op(sel, 1'b0, 1'b1, 4'h0);
         check(tag, dsel(sel), x);
      end
   endtask

   initial begin
      #12;
      check("rst_count", count8, 0);
      check("rst_empty", empty8, 1);
      check("rst_full",  full8,  0);
      check("rst_ae",    ae8,    1);
      check("rst_af",    af8,    0);
      check("rst_werr",  werr8,  0);
      check("rst_rerr",  rerr8,  0);
      check("rst_dout",  dout8,  0);
      @(negedge clk);
      rst = 1'b0;

      // Fill 0x1..0x8
      for (int i = 1; i <= 8; i++) begin
         op(8, 1'b1, 1'b0, 4'(i));
         check("fill_count", count8, i);
         check("fill_af",    af8,    (i >= 7) ? 1 : 0);
         check("fill_full",  full8,  (i == 8) ? 1 : 0);
         check("fill_ae",    ae8,    (i <= 1) ? 1 : 0);
         if (i == 1) check("fill_dout1", dout8, FWFT ? 1 : 0);
      end

      // Overflow write
      op(8, 1'b1, 1'b0, 4'hF);
      check("ovf_werr",  werr8,  1);
      check("ovf_count", count8, 8);
      op(8, 1'b0, 1'b0, 4'h0, 1'b0);
      check("ovf_werr_pulse", werr8, 0);

      // Simultaneous read/write at full: oldest out, 0x9 stored last
      op(8, 1'b1, 1'b1, 4'h9);
      check("rwfull_count", count8, 8);
      check("rwfull_werr",  werr8,  0);
      check("rwfull_full",  full8,  1);
      check("rwfull_dout",  dout8,  FWFT ? 2 : 1);

      // Drain: 0x2..0x9
      for (int k = 0; k < 8; k++) begin
         rd(8, k + 2, "drain_dout");
      end
      check("drain_empty", empty8, 1);
      check("drain_ae",    ae8,    1);
      check("drain_count", count8, 0);
      check("drain_dout_end", dout8, FWFT ? 0 : 9);

      // Underflow read
      op(8, 1'b0, 1'b1, 4'h0);
      check("udf_rerr", rerr8, 1);
      check("udf_dout", dout8, FWFT ? 0 : 9);
      check("udf_count", count8, 0);
      op(8, 1'b0, 1'b0, 4'h0, 1'b0);
      check("udf_rerr_pulse", rerr8, 0);

      // Simultaneous read/write when empty
      op(8, 1'b1, 1'b1, 4'hC);
      check("rwempty_rerr",  rerr8,  1);
      check("rwempty_werr",  werr8,  0);
      check("rwempty_count", count8, 1);
      check("rwempty_empty", empty8, 0);
      check("rwempty_dout",  dout8,  FWFT ? 12 : 9);
      rd(8, 12, "rwempty_read");
      check("rwempty_count0", count8, 0);

      // Five words, then en held low with we/re toggling
      for (int i = 3; i <= 7; i++) begin
         op(8, 1'b1, 1'b0, 4'(i));
      end
      check("five_count", count8, 5);
      for (int i = 0; i < 10; i++) begin
         op(8, i[0], ~i[0], 4'hE, 1'b0);
         check("enlow_count", count8, 5);
         check("enlow_werr",  werr8,  0);
         check("enlow_rerr",  rerr8,  0);
         check("enlow_dout",  dout8,  FWFT ? 3 : 12);
      end

      // Asynchronous reset mid-stream
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_count", count8, 0);
      check("arst_empty", empty8, 1);
      check("arst_ae",    ae8,    1);
      check("arst_full",  full8,  0);
      check("arst_dout",  dout8,  0);
      @(negedge clk);
      rst = 1'b0;

      // Depth 6: wrap pointers through a non-power-of-two range
      for (int i = 1; i <= 4; i++) begin
         op(6, 1'b1, 1'b0, 4'(i));
      end
      check("d6_count4", count6, 4);
      for (int i = 1; i <= 4; i++) begin
         rd(6, i, "d6_rd1");
      end
      check("d6_empty", empty6, 1);
      for (int i = 1; i <= 6; i++) begin
         op(6, 1'b1, 1'b0, 4'(9 + i));
         check("d6_count", count6, i);
         check("d6_af",    af6,    (i >= 5) ? 1 : 0);
         check("d6_full",  full6,  (i == 6) ? 1 : 0);
      end
      op(6, 1'b1, 1'b0, 4'h1);
      check("d6_werr",  werr6,  1);
      check("d6_count6", count6, 6);
      for (int i = 0; i < 6; i++) begin
         rd(6, 10 + i, "d6_rd2");
      end
      check("d6_empty_end", empty6, 1);
      check("d6_ae_end",    ae6,    1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sync_fifo_thresh.md
Name: sync_fifo_thresh

Overview:
Parametrised synchronous FIFO. It replaces the fixed 4-bit, 8-deep FIFO and its board driver.
- All operations are qualified by a single-cycle enable strobe `en`, normally the debounced load-switch pulse.
- Adds occupancy count, programmable almost-full/almost-empty thresholds, registered flags, and non-power-of-two depth support.
- Sits between the switch/button front end and the LED/seven-segment outputs on the board top.

Parameters:
- DATA_WIDTH, 4: width of din/dout.
- FIFO_DEPTH, 8: number of entries; any value ≥2, power of two not required.
- AF_LEVEL, FIFO_DEPTH-1: almost_full asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 1: almost_empty asserts when count ≤ AE_LEVEL.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  operation strobe; we/re are ignored when low.
- we  in  1  write request.
- re  in  1  read request.
- din  in  DATA_WIDTH  write data.
- dout  out  DATA_WIDTH  read data.
- count  out  CW  occupancy, 0..FIFO_DEPTH; CW = clog2(FIFO_DEPTH+1).
- empty  out  1  count==0.
- full  out  1  count==FIFO_DEPTH.
- almost_empty  out  1  count ≤ AE_LEVEL.
- almost_full  out  1  count ≥ AF_LEVEL.
- wr_err  out  1  one-cycle pulse: write rejected.
- rd_err  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset (async, active-high): wr_ptr=0, rd_ptr=0, count=0, dout=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0), wr_err=0, rd_err=0. Memory is not reset.
- Reset asserted mid-operation discards all contents immediately. First accepted op is on the first posedge after rst deasserts.
- en=0: no pointer, count, dout or memory change. Error pulses return to 0.
- Accept rules, evaluated on registered state at the edge:
  - rd_ok = en & re & !empty.
  - wr_ok = en & we & (!full | rd_ok). A simultaneous read allows a write into a full FIFO.
- wr_ok: mem[wr_ptr] <= din. wr_ptr advances, wrapping FIFO_DEPTH-1 → 0 (explicit compare, no reliance on binary overflow).
- rd_ok: dout <= mem[rd_ptr]; rd_ptr advances with the same wrap. Read latency is 1 cycle: data is visible the cycle after the accepting edge. dout holds its value when no read is accepted.
- count: +1 on wr_ok only, −1 on rd_ok only, unchanged on both or neither.
- Simultaneous read and write when empty: write accepted, read rejected (rd_err=1). The written word is readable on the next enabled read.
- All flags are registered, computed from next-state count, and valid the same cycle count updates.
- wr_err = en & we & !wr_ok, registered, high for exactly one cycle.
- rd_err = en & re & !rd_ok, registered, high for exactly one cycle.
- Threshold parameters outside 0..FIFO_DEPTH are a configuration error, flagged by a simulation-only check at time 0.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined: first-word-fall-through.
  - dout continuously shows mem[rd_ptr] whenever !empty, with no read latency.
  - An accepted read advances to the next word on the following cycle.
  - dout is 0 while empty.
- Undefined: registered 1-cycle read latency as described in Behaviour.

Decomposition:
- Package/include sync_fifo_defs: clog2 function and the flag-index localparams used by board tops (EMPTY, FULL, AE, AF, WERR, RERR).
- One sub-module, fifo_regfile: DATA_WIDTH × FIFO_DEPTH register array, one synchronous write port, one asynchronous read port.
- Pointer, count and flag logic stays in the top.

Test Plan:
- Reset, then pulse rst mid-stream with count=5 → count=0, empty=1, almost_empty=1, dout=0 asynchronously, before the next clock edge.
- Defaults: 8 enabled writes of 0x1..0x8 → full=1 after the 8th; almost_full=1 after the 7th; 9th write gives wr_err one-cycle pulse and count stays 8.
- From full, 8 enabled reads → dout 0x1..0x8 each one cycle after the read; empty=1 after the last; a further read gives rd_err pulse and dout holds 0x8.
- FIFO_DEPTH=6: write 4, read 4, write 6 (0xA..0xF) → pointers wrap correctly; reads return 0xA..0xF in order; full at count=6.
- Simultaneous re/we:
  - at full: count stays 8, no wr_err, oldest word out, new word stored last.
  - at empty: rd_err=1, count=1.
- en held low for 10 cycles with we/re toggling → no state change, no error pulses. Repeat with SYNC_FIFO_FWFT_EN: dout shows the first written word the cycle after the write, with no read.
